// File: rtl/midori_mask_pkg.sv
// Shared constants and FSM encoding for the masked Midori S-box serializer.
package midori_mask_pkg;

  localparam int NIB_W   = 4;
  localparam int STATE_W = 64;
  localparam int NIB_CNT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/midori_sbox_serializer_vld_delay_line.sv
// LAT-deep valid shift register matching the external S-box pipeline depth; LAT=0 is a wire.
module vld_delay_line #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (LAT == 0) begin : g_wire
    assign q = d;
  end else begin : g_shift
    logic [LAT-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr <= '0;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < LAT; i++) begin
          sr[i] <= sr[i-1];
        end
      end
    end

    assign q = sr[LAT-1];
  end

endmodule

// File: rtl/midori_sbox_serializer.sv
// Nibble-serial sequencer feeding a 3-share S-box pipeline and reassembling the shared result.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module midori_sbox_serializer
  import midori_mask_pkg::*;
#(
  parameter int SB_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_x1,
  input  logic [63:0] s_x2,
  input  logic [63:0] s_x3,
  output logic        sb_vld,
  output logic [3:0]  sb_x1,
  output logic [3:0]  sb_x2,
  output logic [3:0]  sb_x3,
  input  logic [3:0]  sb_y1,
  input  logic [3:0]  sb_y2,
  input  logic [3:0]  sb_y3,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_y1,
  output logic [63:0] m_y2,
  output logic [63:0] m_y3
);

  fsm_state_t         state, state_nxt;
  logic [3:0]         issue_cnt, cap_cnt;
  logic [STATE_W-1:0] in1, in2, in3;
  logic [STATE_W-1:0] out1, out2, out3;
  logic               cap_vld;

  vld_delay_line #(.LAT(SB_LAT)) u_vld_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sb_vld),
    .q     (cap_vld)
  );

  // Each share has its own mux; shares never meet in this block.
  assign sb_vld  = (state == FEED);
  assign sb_x1   = in1[{issue_cnt, 2'b00} +: NIB_W];
  assign sb_x2   = in2[{issue_cnt, 2'b00} +: NIB_W];
  assign sb_x3   = in3[{issue_cnt, 2'b00} +: NIB_W];
  assign s_ready = (state == IDLE);
  assign m_valid = (state == DONE);
  assign m_y1    = out1;
  assign m_y2    = out2;
  assign m_y3    = out3;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (s_valid) state_nxt = FEED;
      FEED:  if (issue_cnt == 4'(NIB_CNT - 1)) state_nxt = (SB_LAT == 0) ? DONE : DRAIN;
      DRAIN: if (cap_vld && cap_cnt == 4'(NIB_CNT - 1)) state_nxt = DONE;
      DONE:  if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      in1       <= '0;
      in2       <= '0;
      in3       <= '0;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && s_valid) begin
        in1       <= s_x1;
        in2       <= s_x2;
        in3       <= s_x3;
        issue_cnt <= '0;
        cap_cnt   <= '0;
      end
      // Counters wrap back to 0 exactly at the end of their phase.
      if (sb_vld) begin
        issue_cnt <= issue_cnt + 4'd1;
      end
      if (cap_vld) begin
        out1[{cap_cnt, 2'b00} +: NIB_W] <= sb_y1;
        out2[{cap_cnt, 2'b00} +: NIB_W] <= sb_y2;
        out3[{cap_cnt, 2'b00} +: NIB_W] <= sb_y3;
        cap_cnt <= cap_cnt + 4'd1;
      end
    end
  end

endmodule
